// File: rtl/i2c_eeprom_slave.sv
// I2C target modelling a byte-addressable serial EEPROM: fixed device address,
// 1- or 2-byte word address, byte/page writes and current/random/sequential reads.
module i2c_eeprom_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'b1010011,
   parameter int         ADDR_BYTES = 2,
   parameter int         AW         = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl,
   inout  wire         sda,
   output logic        busy,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data
);

   typedef enum logic [3:0] {
      IDLE, DEV_ADDR, DACK, WA_H, AACK_H, WA_L, AACK_L,
      WDATA, WACK, RDATA, RACK, IGNORE
   } state_t;

   state_t      state;
   logic [1:0]  scl_sync, sda_sync;
   logic        scl_q, sda_q;
   logic        scl_s, sda_s;
   logic        scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]  shreg, rx_byte, rd_byte;
   logic [3:0]  bit_cnt;
   logic        ack_phase, rw, sda_oe;
   logic [15:0] ptr, ptr_inc;
   logic [7:0]  mem [2**AW];

   assign sda  = sda_oe ? 1'b0 : 1'bz;
   assign busy = (state != IDLE);

   // Synchronizers reset to the idle-bus level so reset release never looks like an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
         scl_q    <= 1'b1;
         sda_q    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[0], scl};
         sda_sync <= {sda_sync[0], sda};
         scl_q    <= scl_sync[1];
         sda_q    <= sda_sync[1];
      end
   end

   assign scl_s     = scl_sync[1];
   assign sda_s     = sda_sync[1];
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;
   assign rx_byte   = {shreg[6:0], sda_s};

   // Only the low AW bits of the pointer wrap; upper bits are left alone
   always_comb begin
      ptr_inc         = ptr;
      ptr_inc[AW-1:0] = ptr[AW-1:0] + AW'(1);
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sda_oe    <= 1'b0;
         bit_cnt   <= 4'd0;
         shreg     <= 8'd0;
         ack_phase <= 1'b0;
         rw        <= 1'b0;
         ptr       <= 16'd0;
         rd_byte   <= 8'd0;
         wr_en     <= 1'b0;
         wr_addr   <= 16'd0;
         wr_data   <= 8'd0;
      end else begin
         wr_en <= 1'b0;
         if (stop_det) begin
            state     <= IDLE;
            sda_oe    <= 1'b0;
            bit_cnt   <= 4'd0;
            ack_phase <= 1'b0;
         end else if (start_det) begin
            state     <= DEV_ADDR;
            sda_oe    <= 1'b0;
            bit_cnt   <= 4'd0;
            ack_phase <= 1'b0;
         end else begin
            if (scl_rise) shreg <= rx_byte;
            case (state)
               DEV_ADDR: if (scl_rise) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     if (rx_byte[7:1] == SLAVE_ADDR) begin
                        rw      <= rx_byte[0];
                        rd_byte <= mem[ptr[AW-1:0]];
                        state   <= DACK;
                     end else begin
                        state <= IGNORE;
                     end
                  end
               end
               // ACK states: first scl fall pulls sda low, second fall ends the slot
               DACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= 1'b1;
                     ack_phase <= 1'b1;
                  end else begin
                     ack_phase <= 1'b0;
                     if (rw) begin
                        sda_oe  <= ~rd_byte[7];
                        bit_cnt <= 4'd1;
                        state   <= RDATA;
                     end else begin
                        sda_oe <= 1'b0;
                        state  <= (ADDR_BYTES == 2) ? WA_H : WA_L;
                     end
                  end
               end
               WA_H, WA_L, WDATA: if (scl_rise) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     bit_cnt <= 4'd0;
                     if (state == WA_H) begin
                        ptr[15:8] <= rx_byte;
                        state     <= AACK_H;
                     end else if (state == WA_L) begin
                        ptr[7:0] <= rx_byte;
                        state    <= AACK_L;
                     end else begin
                        state <= WACK;
                     end
                  end
               end
               AACK_H, AACK_L: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= 1'b1;
                     ack_phase <= 1'b1;
                  end else begin
                     sda_oe    <= 1'b0;
                     ack_phase <= 1'b0;
                     state     <= (state == AACK_H) ? WA_L : WDATA;
                  end
               end
               WACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_oe    <= 1'b1;
                     ack_phase <= 1'b1;
                     wr_en     <= 1'b1;
                     wr_addr   <= ptr;
                     wr_data   <= shreg;
                     ptr       <= ptr_inc;
                  end else begin
                     sda_oe    <= 1'b0;
                     ack_phase <= 1'b0;
                     state     <= WDATA;
                  end
               end
               RDATA: if (scl_fall) begin
                  if (bit_cnt == 4'd8) begin
                     sda_oe  <= 1'b0;
                     bit_cnt <= 4'd0;
                     state   <= RACK;
                  end else begin
                     sda_oe  <= ~rd_byte[~bit_cnt[2:0]];
                     bit_cnt <= bit_cnt + 4'd1;
                  end
               end
               // Next byte is fetched at the ACK rise so it is ready for the following fall
               RACK: begin
                  if (scl_rise) begin
                     if (!sda_s) begin
                        ptr       <= ptr_inc;
                        rd_byte   <= mem[ptr_inc[AW-1:0]];
                        ack_phase <= 1'b1;
                     end else begin
                        state <= IGNORE;
                     end
                  end else if (scl_fall && ack_phase) begin
                     sda_oe    <= ~rd_byte[7];
                     bit_cnt   <= 4'd1;
                     ack_phase <= 1'b0;
                     state     <= RDATA;
                  end
               end
               IDLE, IGNORE: ;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
